// File: rtl/rx_queue_pkg.sv
// Shared definitions for the rx_queue slice: FSM encodings and
// the flit field helpers used by the write path.
package rx_queue_pkg;

  typedef enum logic [1:0] {
    W_IDLE,
    W_LATCHED,
    W_RC,
    W_STORE
  } w_state_e;

  typedef enum logic [1:0] {
    R_IDLE,
    R_WAIT,
    R_SEND
  } r_state_e;

  // Head flag sits in the flit MSB; destination is everything below it.
  function automatic int head_bit(input int size);
    return size - 1;
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rx_queue_pkt_buf.sv
// Packet slot storage: one synchronous write port and one
// combinational read port; contents are never reset.
module pkt_buf #(
  parameter int W  = 8,
  parameter int AW = 4
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [2**AW];

  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/rx_queue.sv
// Receive queue: two-phase flit channel in, routed packet slots,
// four-phase switch request out.
module rx_queue
  import rx_queue_pkg::*;
#(
  parameter int ID           = 0,
  parameter int SIZE         = 8,
  parameter int PKT_BITS     = 3,
  parameter int SLOT_BITS    = 1,
  parameter int PORT_BITS    = 8,
  parameter int SINK_PACKETS = 0
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 ch_req,
  input  logic [SIZE-1:0]      ch_flit,
  output logic                 ch_ack,
  output logic                 sw_req,
  output logic [PORT_BITS-1:0] sw_chnl,
  input  logic                 sw_gnt,
  input  logic [PKT_BITS-1:0]  buf_addr,
  output logic [SIZE-1:0]      buf_data,
  output logic [SIZE-2:0]      table_addr,
  input  logic [PORT_BITS-1:0] table_data,
  output logic [SLOT_BITS:0]   slots_used,
  output logic [7:0]           err_count
);

  localparam int NSLOT = 2**SLOT_BITS;
  localparam int CW    = SLOT_BITS + 1;
  localparam int HB    = head_bit(SIZE);

  if (ID < 0) begin : g_bad_id
    $error("rx_queue: ID must be non-negative");
  end

  w_state_e w_state_q, w_state_d;
  r_state_e r_state_q, r_state_d;

  logic                 req_seen_q, req_seen_d;
  logic                 ack_q, ack_d;
  logic [SIZE-1:0]      flit_q, flit_d;
  logic [PKT_BITS-1:0]  flit_idx_q, flit_idx_d;
  logic [SLOT_BITS-1:0] wr_slot_q, wr_slot_d;
  logic [SLOT_BITS-1:0] rd_slot_q, rd_slot_d;
  logic [CW-1:0]        slots_q, slots_d;
  logic [7:0]           err_q, err_d;
  logic [SIZE-2:0]      taddr_q, taddr_d;
  logic                 sw_req_q, sw_req_d;
  logic [PORT_BITS-1:0] sw_chnl_q, sw_chnl_d;
  logic [PORT_BITS-1:0] port_q [NSLOT];

  logic req_pend, stall, is_head, idx_zero;
  logic mem_we, port_we, pkt_done, pkt_keep;
  logic slot_free, err_inc;

  assign req_pend = ch_req != req_seen_q;
  assign idx_zero = flit_idx_q == '0;
  assign stall    = idx_zero && (slots_q == CW'(NSLOT));
  assign is_head  = flit_q[HB];

  always_comb begin : next_state
    w_state_d = w_state_q;
    r_state_d = r_state_q;
    unique case (w_state_q)
      W_IDLE:
        if (req_pend && !stall) w_state_d = W_LATCHED;
      W_LATCHED:
        if (is_head)       w_state_d = W_RC;
        else if (idx_zero) w_state_d = W_IDLE;
        else               w_state_d = W_STORE;
      W_RC:    w_state_d = W_STORE;
      W_STORE: w_state_d = W_IDLE;
      default: w_state_d = W_IDLE;
    endcase
    unique case (r_state_q)
      R_IDLE: if (slots_q != '0) r_state_d = R_WAIT;
      R_WAIT: if (sw_gnt)        r_state_d = R_SEND;
      R_SEND: if (!sw_gnt)       r_state_d = R_IDLE;
      default: r_state_d = R_IDLE;
    endcase
  end

  always_comb begin : outputs
    req_seen_d = req_seen_q;
    ack_d      = ack_q;
    flit_d     = flit_q;
    flit_idx_d = flit_idx_q;
    wr_slot_d  = wr_slot_q;
    rd_slot_d  = rd_slot_q;
    slots_d    = slots_q;
    err_d      = err_q;
    taddr_d    = taddr_q;
    sw_req_d   = sw_req_q;
    sw_chnl_d  = sw_chnl_q;
    mem_we     = 1'b0;
    port_we    = 1'b0;
    pkt_done   = 1'b0;
    slot_free  = 1'b0;
    err_inc    = 1'b0;
    unique case (w_state_q)
      W_IDLE:
        if (req_pend && !stall) begin
          flit_d     = ch_flit;
          req_seen_d = ch_req;
        end
      W_LATCHED:
        if (is_head) begin
          taddr_d = flit_q[SIZE-2:0];
          // A head mid-packet restarts the packet in place.
          if (!idx_zero) begin
            err_inc    = 1'b1;
            flit_idx_d = '0;
          end
        end else if (idx_zero) begin
          err_inc = 1'b1;
          ack_d   = ~ack_q;
        end
      W_RC: port_we = 1'b1;
      W_STORE: begin
        mem_we     = 1'b1;
        ack_d      = ~ack_q;
        flit_idx_d = flit_idx_q + PKT_BITS'(1);
        pkt_done   = &flit_idx_q;
      end
      default: ;
    endcase
    unique case (r_state_q)
      R_IDLE:
        if (slots_q != '0) begin
          sw_req_d  = 1'b1;
          sw_chnl_d = port_q[rd_slot_q];
        end
      R_WAIT:
        if (sw_gnt) sw_req_d = 1'b0;
      R_SEND:
        if (!sw_gnt) begin
          slot_free = 1'b1;
          rd_slot_d = rd_slot_q + SLOT_BITS'(1);
        end
      default: ;
    endcase
    pkt_keep = pkt_done && (SINK_PACKETS == 0);
    if (pkt_keep) wr_slot_d = wr_slot_q + SLOT_BITS'(1);
    unique case ({pkt_keep, slot_free})
      2'b10:   slots_d = slots_q + CW'(1);
      2'b01:   slots_d = slots_q - CW'(1);
      default: ;
    endcase
    if (err_inc) err_d = sat_inc(err_q);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      w_state_q  <= W_IDLE;
      r_state_q  <= R_IDLE;
      req_seen_q <= 1'b0;
      ack_q      <= 1'b0;
      flit_q     <= '0;
      flit_idx_q <= '0;
      wr_slot_q  <= '0;
      rd_slot_q  <= '0;
      slots_q    <= '0;
      err_q      <= '0;
      taddr_q    <= '0;
      sw_req_q   <= 1'b0;
      sw_chnl_q  <= '0;
    end else begin
      w_state_q  <= w_state_d;
      r_state_q  <= r_state_d;
      req_seen_q <= req_seen_d;
      ack_q      <= ack_d;
      flit_q     <= flit_d;
      flit_idx_q <= flit_idx_d;
      wr_slot_q  <= wr_slot_d;
      rd_slot_q  <= rd_slot_d;
      slots_q    <= slots_d;
      err_q      <= err_d;
      taddr_q    <= taddr_d;
      sw_req_q   <= sw_req_d;
      sw_chnl_q  <= sw_chnl_d;
    end
  end

  always_ff @(posedge clk) begin
    if (port_we) port_q[wr_slot_q] <= table_data;
  end

  pkt_buf #(
    .W  (SIZE),
    .AW (SLOT_BITS + PKT_BITS)
  ) u_buf (
    .clk   (clk),
    .we    (mem_we),
    .waddr ({wr_slot_q, flit_idx_q}),
    .wdata (flit_q),
    .raddr ({rd_slot_q, buf_addr}),
    .rdata (buf_data)
  );

  assign ch_ack     = ack_q;
  assign sw_req     = sw_req_q;
  assign sw_chnl    = sw_chnl_q;
  assign table_addr = taddr_q;
  assign slots_used = slots_q;
  assign err_count  = err_q;

endmodule
